// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and write-priority helper for regfile_mp
package regfile_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [63:0] reg_data_t;

  localparam int MAX_NW = 2;
  localparam int MAX_AW = 16;

  typedef logic [MAX_AW-1:0] wide_addr_t;

  typedef struct packed {
    logic hit;
    logic port;
  } hit_t;

  // Later ports overwrite earlier matches, so the highest-indexed writer wins.
  function automatic hit_t write_hit(input wide_addr_t addr,
                                     input wide_addr_t [MAX_NW-1:0] wa,
                                     input logic [MAX_NW-1:0] we);
    hit_t h;
    h = '0;
    for (int j = 0; j < MAX_NW; j++) begin
      if (we[j] && (wa[j] == addr)) begin
        h.hit  = 1'b1;
        h.port = j[0];
      end
    end
    return h;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits for RAW hazard detection
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int N    = 32,
  parameter int AW   = 5,
  parameter int NR   = 2,
  parameter int ZREG = 31
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NR*AW-1:0]            ra,
  input  wide_addr_t [MAX_NW-1:0]     wa_ext,
  input  logic [MAX_NW-1:0]           we_ext,
  input  logic [MAX_NW-1:0]           we_byp,
  input  logic                        iss_en,
  input  logic [AW-1:0]               iss_a,
  output logic [NR-1:0]               rbusy,
  output logic                        any_busy
);

  logic [N-1:0] busy_q;
  logic [N-1:0] busy_d;

  function automatic logic addr_live(input logic [AW-1:0] a);
    return (32'(a) < N) && (32'(a) != ZREG);
  endfunction

  // Clear on retire first, then set on issue so a new producer supersedes it.
  always_comb begin
    hit_t h;
    h      = '0;
    busy_d = busy_q;
    for (int r = 0; r < N; r++) begin
      h = write_hit(wide_addr_t'(r), wa_ext, we_ext);
      if (h.hit) busy_d[r] = 1'b0;
      if (iss_en && (32'(iss_a) == r) && (r != ZREG)) busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    hit_t          h;
    logic [AW-1:0] a;
    h     = '0;
    a     = '0;
    rbusy = '0;
    for (int i = 0; i < NR; i++) begin
      a = ra[i*AW +: AW];
      h = write_hit(wide_addr_t'(a), wa_ext, we_byp);
      if (addr_live(a)) rbusy[i] = busy_q[a] && !h.hit;
    end
  end

  assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with zero register, bypass and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int W      = 64,
  parameter int N      = 32,
  parameter int NR     = 2,
  parameter int NW     = 2,
  parameter int ZREG   = int'(XZR),
  parameter int BYPASS = 1,
  localparam int AW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NR*AW-1:0]  ra,
  output logic [NR*W-1:0]   rd,
  output logic [NR-1:0]     rbusy,
  input  logic [NW*AW-1:0]  wa,
  input  logic [NW*W-1:0]   wd,
  input  logic [NW-1:0]     we,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_a,
  output logic              any_busy
);

  logic [W-1:0] regs_q [N];
  logic [W-1:0] regs_d [N];

  wide_addr_t [MAX_NW-1:0] wa_ext;
  logic [MAX_NW-1:0]       we_ext;
  logic [MAX_NW-1:0]       we_byp;
  logic [W-1:0]            wd_arr [MAX_NW];

  function automatic logic addr_live(input logic [AW-1:0] a);
    return (32'(a) < N) && (32'(a) != ZREG);
  endfunction

  // Bypass is suppressed under reset so reads show only stored (cleared) state.
  always_comb begin
    wa_ext = '0;
    we_ext = '0;
    we_byp = '0;
    for (int j = 0; j < MAX_NW; j++) wd_arr[j] = '0;
    for (int j = 0; j < NW; j++) begin
      wa_ext[j][AW-1:0] = wa[j*AW +: AW];
      we_ext[j]         = we[j];
      wd_arr[j]         = wd[j*W +: W];
    end
    if (BYPASS != 0) we_byp = we_ext & {MAX_NW{~reset}};
  end

  always_comb begin
    hit_t h;
    h      = '0;
    regs_d = regs_q;
    for (int r = 0; r < N; r++) begin
      h = write_hit(wide_addr_t'(r), wa_ext, we_ext);
      if (h.hit && (r != ZREG)) regs_d[r] = wd_arr[h.port];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  always_comb begin
    hit_t          h;
    logic [AW-1:0] a;
    h  = '0;
    a  = '0;
    rd = '0;
    for (int i = 0; i < NR; i++) begin
      a = ra[i*AW +: AW];
      h = write_hit(wide_addr_t'(a), wa_ext, we_byp);
      if (addr_live(a)) begin
        if (h.hit) rd[i*W +: W] = wd_arr[h.port];
        else       rd[i*W +: W] = regs_q[a];
      end
    end
  end

  regfile_scoreboard #(
    .N    (N),
    .AW   (AW),
    .NR   (NR),
    .ZREG (ZREG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .ra       (ra),
    .wa_ext   (wa_ext),
    .we_ext   (we_ext),
    .we_byp   (we_byp),
    .iss_en   (iss_en),
    .iss_a    (iss_a),
    .rbusy    (rbusy),
    .any_busy (any_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp, bypass and non-bypass instances
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int W = 64, N = 32, AW = 5, NR = 2, NW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  ra;
  logic [NR*W-1:0]   rd, rd_nb;
  logic [NR-1:0]     rbusy, rbusy_nb;
  logic [NW*AW-1:0]  wa;
  logic [NW*W-1:0]   wd;
  logic [NW-1:0]     we;
  logic              iss_en;
  logic [AW-1:0]     iss_a;
  logic              any_busy, any_busy_nb;

  always #5 clk = ~clk;

  regfile_mp #(.W(W), .N(N), .NR(NR), .NW(NW), .ZREG(31), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy), .wa(wa), .wd(wd),
    .we(we), .iss_en(iss_en), .iss_a(iss_a), .any_busy(any_busy));

  regfile_mp #(.W(W), .N(N), .NR(NR), .NW(NW), .ZREG(31), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd_nb), .rbusy(rbusy_nb), .wa(wa), .wd(wd),
    .we(we), .iss_en(iss_en), .iss_a(iss_a), .any_busy(any_busy_nb));

  typedef struct {
    string     tag;
    int        kind;
    int        port;
    reg_data_t val;
  } exp_t;

  exp_t      exp_q[$];
  int        n_cmp = 0;
  int        n_bad = 0;
  reg_data_t m_mem [32];
  logic [31:0] m_busy;

  task automatic check_eq(input string tag, input reg_data_t obs, input reg_data_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind: 0 rd, 1 rbusy, 2 any_busy (bypass dut); 3 rd, 4 rbusy, 5 any_busy (no-bypass dut)
  function automatic reg_data_t observe(input int kind, input int port);
    case (kind)
      0:       return rd[port*W +: W];
      1:       return {63'd0, rbusy[port]};
      2:       return {63'd0, any_busy};
      3:       return rd_nb[port*W +: W];
      4:       return {63'd0, rbusy_nb[port]};
      default: return {63'd0, any_busy_nb};
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input int port, input reg_data_t val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.port = port; e.val = val;
    exp_q.push_back(e);
  endtask

  function automatic logic wr_hit_port(input int j, input int a);
    return we[j] && (int'(wa[j*AW +: AW]) == a) && !reset;
  endfunction

  function automatic reg_data_t m_rd(input int a, input bit byp);
    if (a == 31) return '0;
    if (byp && wr_hit_port(1, a)) return wd[127:64];
    if (byp && wr_hit_port(0, a)) return wd[63:0];
    return m_mem[a];
  endfunction

  function automatic reg_data_t m_rbusy(input int a, input bit byp);
    if (a == 31) return '0;
    if (byp && (wr_hit_port(0, a) || wr_hit_port(1, a))) return '0;
    return {63'd0, m_busy[a]};
  endfunction

  task automatic predict();
    int a;
    for (int p = 0; p < NR; p++) begin
      a = int'(ra[p*AW +: AW]);
      push($sformatf("m_rd%0d_a%0d", p, a), 0, p, m_rd(a, 1'b1));
      push($sformatf("m_rbusy%0d_a%0d", p, a), 1, p, m_rbusy(a, 1'b1));
      push($sformatf("m_rd_nb%0d_a%0d", p, a), 3, p, m_rd(a, 1'b0));
      push($sformatf("m_rbusy_nb%0d_a%0d", p, a), 4, p, m_rbusy(a, 1'b0));
    end
    push("m_any_busy", 2, 0, {63'd0, |m_busy});
    push("m_any_busy_nb", 5, 0, {63'd0, |m_busy});
  endtask

  task automatic model_update();
    if (reset) begin
      for (int r = 0; r < 32; r++) m_mem[r] = '0;
      m_busy = '0;
    end else begin
      if (we[0] && wa[4:0] != 5'd31) m_mem[wa[4:0]] = wd[63:0];
      if (we[1] && wa[9:5] != 5'd31) m_mem[wa[9:5]] = wd[127:64];
      if (we[0]) m_busy[wa[4:0]] = 1'b0;
      if (we[1]) m_busy[wa[9:5]] = 1'b0;
      if (iss_en && iss_a != 5'd31) m_busy[iss_a] = 1'b1;
    end
  endtask

  task automatic drive(input logic rst, input int r0, input int r1, input logic [1:0] wev,
                       input int a0, input int a1, input reg_data_t d0, input reg_data_t d1,
                       input logic ie, input int ia);
    reset  = rst;
    ra     = {r1[4:0], r0[4:0]};
    we     = wev;
    wa     = {a1[4:0], a0[4:0]};
    wd     = {d1, d0};
    iss_en = ie;
    iss_a  = ia[4:0];
    predict();
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, observe(e.kind, e.port), e.val);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic int rand_a();
    int v;
    v = int'($urandom_range(0, 8));
    return (v == 8) ? 31 : v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ra = '0; we = '0; wa = '0; wd = '0; iss_en = 1'b0; iss_a = '0;
    @(posedge clk);
    model_update();
    #1;

    // reset held: stored state cleared, writes and issue ignored
    drive(1'b1, 18, 7, 2'b11, 18, 7, 64'd5, 64'd6, 1'b1, 7);
    push("rst_rd0", 0, 0, 64'd0);
    push("rst_any_busy", 2, 0, 64'd0);
    tick();

    for (int k = 0; k < 32; k++) begin
      drive(1'b0, k, k, 2'b00, 0, 0, 64'd0, 64'd0, 1'b0, 0);
      push($sformatf("sweep_rd_%0d", k), 0, 1, 64'd0);
      push($sformatf("sweep_rbusy_%0d", k), 1, 0, 64'd0);
      tick();
    end

    drive(1'b0, 18, 0, 2'b01, 18, 0, 64'd69, 64'd0, 1'b0, 0);
    push("byp_same_cycle", 0, 0, 64'd69);
    push("nobyp_same_cycle", 3, 0, 64'd0);
    tick();
    drive(1'b0, 18, 0, 2'b00, 0, 0, 64'd0, 64'd0, 1'b0, 0);
    push("byp_after_edge", 0, 0, 64'd69);
    push("nobyp_after_edge", 3, 0, 64'd69);
    tick();

    drive(1'b0, 5, 5, 2'b11, 5, 5, 64'd9, 64'd10, 1'b0, 0);
    push("collide_byp", 0, 0, 64'd10);
    tick();
    drive(1'b0, 5, 31, 2'b01, 31, 0, 64'd77, 64'd0, 1'b0, 0);
    push("collide_stored", 3, 0, 64'd10);
    push("xzr_byp", 0, 1, 64'd0);
    tick();
    drive(1'b0, 5, 31, 2'b00, 0, 0, 64'd0, 64'd0, 1'b0, 0);
    push("xzr_stored", 3, 1, 64'd0);
    tick();

    drive(1'b0, 7, 0, 2'b00, 0, 0, 64'd0, 64'd0, 1'b1, 7);
    push("iss_not_yet", 1, 0, 64'd0);
    tick();
    drive(1'b0, 7, 0, 2'b00, 0, 0, 64'd0, 64'd0, 1'b0, 0);
    push("iss_busy", 1, 0, 64'd1);
    push("iss_any_busy", 2, 0, 64'd1);
    tick();
    drive(1'b0, 7, 0, 2'b10, 0, 7, 64'd0, 64'd3, 1'b0, 0);
    push("retire_byp_mask", 1, 0, 64'd0);
    push("retire_nobyp_busy", 4, 0, 64'd1);
    push("retire_rd", 0, 0, 64'd3);
    tick();
    drive(1'b0, 7, 0, 2'b00, 0, 0, 64'd0, 64'd0, 1'b0, 0);
    push("retire_cleared", 4, 0, 64'd0);
    push("retire_any_busy", 2, 0, 64'd0);
    tick();

    drive(1'b0, 7, 0, 2'b01, 7, 0, 64'd4, 64'd0, 1'b1, 7);
    tick();
    drive(1'b0, 7, 31, 2'b00, 0, 0, 64'd0, 64'd0, 1'b1, 31);
    push("set_wins_rd", 3, 0, 64'd4);
    push("set_wins_busy", 4, 0, 64'd1);
    tick();
    drive(1'b0, 31, 7, 2'b00, 0, 0, 64'd0, 64'd0, 1'b0, 0);
    push("iss_xzr_rbusy", 4, 0, 64'd0);
    tick();
    drive(1'b0, 7, 0, 2'b10, 0, 7, 64'd0, 64'd1, 1'b0, 0);
    tick();

    drive(1'b0, 3, 0, 2'b01, 3, 0, 64'd55, 64'd0, 1'b1, 3);
    tick();
    drive(1'b0, 3, 0, 2'b00, 0, 0, 64'd0, 64'd0, 1'b0, 0);
    push("pre_rst_rd", 3, 0, 64'd55);
    push("pre_rst_busy", 4, 0, 64'd1);
    tick();
    drive(1'b1, 3, 0, 2'b01, 3, 0, 64'd8, 64'd0, 1'b0, 0);
    push("in_rst_rd", 0, 0, 64'd55);
    tick();
    drive(1'b0, 3, 0, 2'b00, 0, 0, 64'd0, 64'd0, 1'b0, 0);
    push("post_rst_rd", 0, 0, 64'd0);
    push("post_rst_busy", 1, 0, 64'd0);
    push("post_rst_any", 2, 0, 64'd0);
    tick();

    for (int c = 0; c < 60; c++) begin
      drive(($urandom_range(0, 15) == 0), rand_a(), rand_a(), 2'($urandom_range(0, 3)),
            rand_a(), rand_a(), {$urandom, $urandom}, {$urandom, $urandom},
            1'($urandom_range(0, 1)), rand_a());
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, dual-read 32x64 LEGv8 register file.
- Configurable data width, depth, read-port count and write-port count.
- Hardwired zero register (XZR).
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard so the decode stage can detect RAW hazards against in-flight producers.
- Sits between decode (reads, issue) and writeback (writes) in the pipelined datapath.

Parameters:
- W, 64, data width in bits.
- N, 32, number of registers; address width AW = $clog2(N).
- NR, 2, number of read ports (1..4).
- NW, 2, number of write ports (1..2).
- ZREG, 31, index of hardwired zero register; N means none.
- BYPASS, 1, 1 = a write in the current cycle is visible on read ports in that cycle; 0 = visible after the clock edge only.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous active-high reset.
- ra  in  NR*AW  read addresses, port i at [i*AW +: AW].
- rd  out  NR*W  read data, port i at [i*W +: W].
- rbusy  out  NR  busy flag of the register addressed by ra port i.
- wa  in  NW*AW  write addresses.
- wd  in  NW*W  write data.
- we  in  NW  write enables.
- iss_en  in  1  issue strobe: marks iss_a as having a pending producer.
- iss_a  in  AW  destination register of the issued instruction.
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Storage: N x W flops; reads are combinational; writes take effect on posedge clk.
- Reset (synchronous, reset=1 at posedge):
  - All registers cleared to 0; all busy bits cleared.
  - reset overrides every we and iss_en in that cycle.
  - Reset mid-operation discards pending writes with no partial update.
  - While reset is high, rd reflects the stored values: 0 after the first edge. rbusy=0 and any_busy=0 after the first edge.
- Write ports:
  - Port j writes wd[j] to reg wa[j] when we[j]=1.
  - Two ports writing the same address in one cycle: the higher port index (port 1) wins.
  - Writes to ZREG are dropped.
  - Out-of-range addresses (>= N when N is not a power of 2) are dropped for writes and read as 0.
- Read ports:
  - rd[i] = 0 if ra[i]==ZREG.
  - Else, if BYPASS=1 and any we[j]=1 with wa[j]==ra[i]: the winning write's wd (same priority as storage).
  - Else the stored value.
  - With BYPASS=0, reads return the pre-edge stored value in the cycle of the write.
- Scoreboard:
  - busy[r] is set at posedge when iss_en=1 and iss_a==r (r != ZREG).
  - busy[r] is cleared at posedge when any we[j]=1 with wa[j]==r.
  - If issue and write target the same r in the same cycle, set wins: the new producer supersedes the retiring one. The data write still occurs.
  - Issuing to ZREG is ignored.
  - rbusy[i] = busy[ra[i]], masked to 0 when ra[i]==ZREG. When BYPASS=1 it is also masked to 0 when a write to ra[i] occurs in this cycle.
  - any_busy is the OR of all busy bits, registered state only (no bypass).
- No internal latency beyond one edge for writes and scoreboard. No stalls generated internally; hazard resolution belongs to the pipeline controller.
- Writes to different registers from both ports in the same cycle both commit.

Decomposition:
- Package regfile_pkg holds:
  - localparam XZR = 5'd31.
  - Typedef reg_addr_t = logic [4:0].
  - Typedef reg_data_t = logic [63:0].
  - Function write_hit(addr, wa, we), returning hit flag and winning port index. It is shared by the storage write and the bypass so both use the same priority.
- One sub-module, regfile_scoreboard: busy vector, set/clear priority, rbusy/any_busy generation. Storage and bypass stay in regfile_mp.

Test Plan:
- Reset, then sweep ra[0]=ra[1]=k for k=0..31 -> rd all 0, rbusy all 0, any_busy=0.
- we[0]=1, wa[0]=18, wd[0]=69, ra[0]=18 with BYPASS=1 -> rd[0]=69 in the same cycle; after the edge with we=0 -> still 69. With BYPASS=0 -> rd[0] stays 0 until after the edge.
- Same-cycle collision: we=2'b11, wa[0]=wa[1]=5, wd[0]=9, wd[1]=10 -> next cycle reg5=10. Write to 31 with wd=77 -> ra=31 reads 0.
- iss_en=1, iss_a=7 -> next cycle rbusy for ra=7 is 1 and any_busy=1. we[1]=1, wa[1]=7, wd=3 -> rbusy for ra=7 goes 0 in the same cycle (bypass); busy bit clears after the edge.
- Simultaneous iss_en with iss_a=7 and we[0] with wa=7, wd=4 -> reg7=4 and busy[7] stays 1. iss_a=31 -> no busy set.
- Mid-operation reset: busy[3]=1, reg3=55, assert reset together with we[0] (wa=3, wd=8) -> after the edge reg3=0, busy[3]=0, any_busy=0.
